// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the chunked, pipelined add/sub datapath.
package add_sub_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle for add_sub_pipe; flush rides along with the request side.
interface add_sub_pipe_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output flush, in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  flush, in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/add_sub_pipe_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB for overflow.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out by xor
  assign c_msb_in  = a[W-1] ^ b[W-1] ^ s[W-1];
endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub: one CHUNK per stage, carry and skewed operands travel with the op.
module add_sub_pipe
  import add_sub_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  add_sub_pipe_if.slave    bus
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  typedef struct packed {
    logic             vld;
    logic             carry;
    logic             c_msb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t [STAGES-1:0] st_q, st_d;
  stage_t              fin;
  logic                stall, acc, c0;
  logic [WIDTH-1:0]    b0;

  assign fin          = st_q[STAGES-1];
  assign stall        = fin.vld && !bus.out_ready;
  assign bus.in_ready = !stall && !bus.flush;
  assign acc          = bus.in_valid && bus.in_ready;
  assign b0           = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign c0           = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src, nxt;
    logic [CHUNK-1:0] cs;
    logic             co, cm;

    if (k == 0) begin : g_in
      always_comb begin
        src       = '0;
        src.vld   = acc;
        src.carry = c0;
        src.a     = bus.a;
        src.b     = b0;
      end
    end else begin : g_fwd
      assign src = st_q[k-1];
    end

    add_chunk #(.W(CHUNK)) u_chunk (
      .a        (src.a[k*CHUNK +: CHUNK]),
      .b        (src.b[k*CHUNK +: CHUNK]),
      .cin      (src.carry),
      .s        (cs),
      .cout     (co),
      .c_msb_in (cm)
    );

    always_comb begin
      nxt                      = src;
      nxt.s[k*CHUNK +: CHUNK]  = cs;
      nxt.carry                = co;
      nxt.c_msb                = cm;
    end

    assign st_d[k] = nxt;
  end

  // flush wins over stall so a blocked output can still be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < STAGES; k++) st_q[k].vld <= 1'b0;
    end else if (!stall) begin
      st_q <= st_d;
    end
  end

  // results and flags are masked so bubbles never expose stale data
  assign bus.out_valid = fin.vld;
  assign bus.sum       = fin.vld ? fin.s : '0;
  assign bus.cout      = fin.vld & fin.carry;
  assign bus.ovf       = fin.vld & (fin.carry ^ fin.c_msb);
  assign bus.zero      = fin.vld & (fin.s == '0);
  assign bus.neg       = fin.vld & fin.s[WIDTH-1];
endmodule
